// File: rtl/tr_pulse_gen_if.sv
// Command/status bundle between the TR mode mux and the step/direction pulse generator.
// Latency: none, plain wires.
// Backpressure: none; the generator always accepts its command inputs.
interface tr_pulse_gen_if #(
  parameter int WIDTH_TR = 16
);
  logic                drv_en_TR;
  logic                dir_TR;
  logic                counter_en_TR;
  logic [WIDTH_TR-1:0] period_TR;
  logic [WIDTH_TR-1:0] pulse_number;
  logic                start;
  logic                step;
  logic                dir;
  logic                busy;
  logic                done;
  logic [WIDTH_TR-1:0] pulse_cnt;

  // Command side (mode mux / test driver)
  modport master (
    output drv_en_TR, dir_TR, counter_en_TR, period_TR, pulse_number, start,
    input  step, dir, busy, done, pulse_cnt
  );

  // Generator side
  modport slave (
    input  drv_en_TR, dir_TR, counter_en_TR, period_TR, pulse_number, start,
    output step, dir, busy, done, pulse_cnt
  );
endinterface

// File: rtl/tr_pulse_gen.sv
// Step/direction pulse generator (counted or free run); macro TR_DIR_SETUP_EN adds a direction setup dwell.
// Latency: all outputs registered; step rises the cycle after the run is accepted in IDLE.
// Backpressure: none; drv_en_TR low aborts motion on the next cycle, rst wins over everything.
module tr_pulse_gen #(
  parameter int WIDTH_TR  = 16,
  parameter int DIR_SETUP = 8
) (
  input  logic          clk,
  input  logic          rst,
  tr_pulse_gen_if.slave bus
);

  // The cycle counter is shared between step periods and the setup dwell,
  // so it is wide enough for whichever is longer.
  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam int CW = (WIDTH_TR > SW) ? WIDTH_TR : SW;

  typedef logic [WIDTH_TR-1:0] tr_t;
  typedef logic [CW-1:0]       cyc_t;

`ifdef TR_DIR_SETUP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
`endif

  state_t r_state;
  logic   r_mode;      // 1 = counted run, latched when the run starts
  tr_t    r_pn;        // target pulse count for a counted run
  tr_t    r_cnt;       // completed periods, saturating
  tr_t    r_per;       // effective period of the period in progress
  cyc_t   r_cyc;       // cycle index inside the period / setup dwell
  logic   r_step;
  logic   r_dir;
  logic   r_busy;
  logic   r_done;

  tr_t    w_per_eff;
  cyc_t   w_cyc_nxt;
  logic   w_last;
  logic   w_step_nxt;
  tr_t    w_cnt_inc;
  logic   w_cnt_reach;
  logic   w_go;

  // Periods shorter than 2 cycles cannot show both a high and a low phase.
  assign w_per_eff   = (bus.period_TR < tr_t'(2)) ? tr_t'(2) : bus.period_TR;
  assign w_cyc_nxt   = r_cyc + cyc_t'(1);
  assign w_last      = (r_cyc == (cyc_t'(r_per) - cyc_t'(1)));
  // High for the first floor(Pe/2) cycles of the period.
  assign w_step_nxt  = (w_cyc_nxt < cyc_t'(r_per >> 1));
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : (r_cnt + tr_t'(1));
  assign w_cnt_reach = (w_cnt_inc >= r_pn);
  assign w_go        = bus.drv_en_TR & (~bus.counter_en_TR | bus.start);

`ifdef TR_DIR_SETUP_EN
  logic w_dir_chg;
  logic w_setup_last;
  assign w_dir_chg    = (bus.dir_TR != r_dir);
  assign w_setup_last = (r_cyc == cyc_t'(DIR_SETUP - 1));
`endif

  // Control FSM with registered step/dir/busy/done and the pulse counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_pn    <= '0;
      r_cnt   <= '0;
      r_per   <= '0;
      r_cyc   <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_step <= 1'b0;
          if (w_go) begin
            r_mode <= bus.counter_en_TR;
            r_pn   <= bus.pulse_number;
            r_cnt  <= '0;
            r_dir  <= bus.dir_TR;
            r_busy <= 1'b1;
            r_cyc  <= '0;
            if (bus.counter_en_TR && (bus.pulse_number == '0)) begin
              // Zero-length counted run: report completion without stepping.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
`ifdef TR_DIR_SETUP_EN
            end else if (w_dir_chg) begin
              r_state <= ST_SETUP;
`endif
            end else begin
              r_state <= ST_RUN;
              r_per   <= w_per_eff;
              r_step  <= 1'b1;
            end
          end
        end

`ifdef TR_DIR_SETUP_EN
        ST_SETUP: begin
          if (!bus.drv_en_TR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
          end else if (w_setup_last) begin
            // Dwell over: open a fresh period with the current period_TR.
            r_state <= ST_RUN;
            r_per   <= w_per_eff;
            r_cyc   <= '0;
            r_step  <= 1'b1;
          end else begin
            r_cyc <= w_cyc_nxt;
          end
        end
`endif

        ST_RUN: begin
          if (!bus.drv_en_TR) begin
            // Abort: pulse_cnt keeps the periods already completed.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
          end else if (w_last) begin
            r_cnt <= w_cnt_inc;
            r_cyc <= '0;
            if (r_mode && w_cnt_reach) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_step  <= 1'b0;
            end else begin
              // Period boundary: the only place dir may follow dir_TR mid-run.
              r_dir <= bus.dir_TR;
`ifdef TR_DIR_SETUP_EN
              if (w_dir_chg) begin
                r_state <= ST_SETUP;
                r_step  <= 1'b0;
              end else begin
                r_per  <= w_per_eff;
                r_step <= 1'b1;
              end
`else
              r_per  <= w_per_eff;
              r_step <= 1'b1;
`endif
            end
          end else begin
            r_cyc  <= w_cyc_nxt;
            r_step <= w_step_nxt;
          end
        end

        ST_DONE: begin
          // Starts seen here are dropped; a new run needs a start in IDLE.
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_step  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_step  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step      = r_step;
  assign bus.dir       = r_dir;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pulse_cnt = r_cnt;

endmodule
